// File: rtl/mem_copier.sv
// Word-by-word copier for a single-port memory with a one-cycle registered read.
// Each word is copied in three cycles: address the source, capture the read data, write the destination.
module mem_copier #(
    parameter int s = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [s-1:0] srcAddr,
    input  logic [s-1:0] dstAddr,
    input  logic [s:0]   length,
    output logic         busy,
    output logic         done,
    output logic [s:0]   wordsCopied,
    output logic [s-1:0] memAddress,
    output logic         memWrite,
    output logic [31:0]  memDataOut,
    input  logic [31:0]  memDataIn
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state_reg;
    logic [s-1:0] src_reg;
    logic [s-1:0] dst_reg;
    logic [s:0]   len_reg;
    logic [s:0]   idx_reg;
    logic [31:0]  buf_reg;
    logic         busy_reg;
    logic         done_reg;
    logic [s-1:0] addr_reg;
    logic         write_reg;

    logic [s:0]   idx_inc;
    logic [s-1:0] next_src_addr;
    logic [s-1:0] dst_addr;

    assign idx_inc       = idx_reg + {{s{1'b0}}, 1'b1};
    assign next_src_addr = src_reg + idx_inc[s-1:0];
    assign dst_addr      = dst_reg + idx_reg[s-1:0];

    // The word index doubles as the completed-write count.
    assign wordsCopied = idx_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign memAddress  = addr_reg;
    assign memWrite    = write_reg;
    assign memDataOut  = buf_reg;

    // Outputs are registered: each transition loads the values belonging to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            buf_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_reg <= srcAddr;
                        dst_reg <= dstAddr;
                        len_reg <= length;
                        idx_reg <= '0;
                        if (length != '0) begin
                            state_reg <= READ;
                            busy_reg  <= 1'b1;
                            addr_reg  <= srcAddr;
                        end else begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    addr_reg <= '0;
                    if (abort) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= LATCH;
                    end
                end
                LATCH: begin
                    buf_reg <= memDataIn;
                    if (abort) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= WRITE;
                        addr_reg  <= dst_addr;
                        write_reg <= 1'b1;
                    end
                end
                WRITE: begin
                    // The write in flight this cycle is committed and counted even when aborting.
                    idx_reg   <= idx_inc;
                    write_reg <= 1'b0;
                    if (abort || (idx_inc == len_reg)) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        addr_reg  <= '0;
                    end else begin
                        state_reg <= READ;
                        addr_reg  <= next_src_addr;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    addr_reg  <= '0;
                    write_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copier.sv
// Randomized bench for mem_copier: a registered-read memory model plus a sequential
// word-copy reference that predicts per-cycle outputs and final memory contents.
module tb_mem_copier;

    localparam int AW   = 12;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] srcAddr;
    logic [AW-1:0] dstAddr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW:0]   wordsCopied;
    logic [AW-1:0] memAddress;
    logic          memWrite;
    logic [31:0]   memDataOut;
    logic [31:0]   memDataIn;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    logic [31:0]   mem     [0:MASK];
    logic [31:0]   ref_mem [0:MASK];

    int n_checks = 0;
    int n_fail   = 0;

    mem_copier #(.s(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .srcAddr     (srcAddr),
        .dstAddr     (dstAddr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .wordsCopied (wordsCopied),
        .memAddress  (memAddress),
        .memWrite    (memWrite),
        .memDataOut  (memDataOut),
        .memDataIn   (memDataIn)
    );

    always #5 clk = ~clk;

    // Single-port memory, one-cycle registered read; the preload port is bench-only.
    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (memWrite)
            mem[memAddress] <= memDataOut;
        memDataIn <= mem[memAddress];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int addr, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_addr = addr[AW-1:0];
        pl_data = data;
        ref_mem[addr & MASK] = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Runs one copy; abort_c / extra_c name the cycle (1 = first after the start edge) in which
    // abort or a spurious start is driven, 0 for none.
    task automatic run_copy(input int src, input int dst, input int len,
                            input int abort_c, input int extra_c);
        int words;
        int done_exp;
        int p;
        int k;
        int exp_a;
        logic [31:0] wdata[$];
        logic [31:0] d;
        logic [AW:0] len_v;

        words    = len;
        done_exp = 3 * len + 1;
        if (abort_c > 0 && abort_c <= 3 * len) begin
            words    = (abort_c - 1) / 3 + (((abort_c - 1) % 3 == 2) ? 1 : 0);
            done_exp = abort_c + 1;
        end
        for (int i = 0; i < words; i++) begin
            d = ref_mem[(src + i) & MASK];
            wdata.push_back(d);
            ref_mem[(dst + i) & MASK] = d;
        end

        len_v   = len[AW:0];
        start   = 1'b1;
        srcAddr = src[AW-1:0];
        dstAddr = dst[AW-1:0];
        length  = len_v;
        for (int c = 1; c <= done_exp + 1; c++) begin
            @(negedge clk);
            start   = 1'b0;
            srcAddr = AW'($urandom);
            dstAddr = AW'($urandom);
            length  = (AW+1)'($urandom);
            if (c < done_exp) begin
                p = (c - 1) % 3;
                k = (c - 1) / 3;
                exp_a = (p == 0) ? ((src + k) & MASK) : (p == 1) ? 0 : ((dst + k) & MASK);
                check("busy", 64'(busy), 64'd1);
                check("done_early", 64'(done), 64'd0);
                check("mem_address", 64'(memAddress), 64'(exp_a));
                check("mem_write", 64'(memWrite), (p == 2) ? 64'd1 : 64'd0);
                if (p == 2 && k < words)
                    check("mem_data_out", 64'(memDataOut), 64'(wdata[k]));
            end else if (c == done_exp) begin
                check("done_pulse", 64'(done), 64'd1);
                check("busy_in_done", 64'(busy), 64'd0);
                check("write_in_done", 64'(memWrite), 64'd0);
                check("addr_in_done", 64'(memAddress), 64'd0);
                check("words_in_done", 64'(wordsCopied), 64'(words));
            end else begin
                check("done_after", 64'(done), 64'd0);
                check("busy_idle", 64'(busy), 64'd0);
                check("words_idle", 64'(wordsCopied), 64'(words));
            end
            abort = (c == abort_c);
            if (c == extra_c) start = 1'b1;
        end
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i <= words && i <= MASK; i++)
            check("final_mem", 64'(mem[(dst + i) & MASK]), 64'(ref_mem[(dst + i) & MASK]));
        $display("copy src=%03h dst=%03h len=%0d abort_c=%0d words=%0d done_cycle=%0d",
                 src, dst, len, abort_c, words, done_exp);
    endtask

    initial begin
        int len;
        int ab;
        int ex;
        bit saw_write;
        bit saw_done;

        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        srcAddr = '0;
        dstAddr = '0;
        length  = '0;
        pl_en   = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        @(negedge clk);
        for (int i = 0; i <= MASK; i++) poke(i, $urandom);

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_words", 64'(wordsCopied), 64'd0);
        check("rst_addr", 64'(memAddress), 64'd0);
        check("rst_write", 64'(memWrite), 64'd0);
        check("rst_data", 64'(memDataOut), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic four-word copy with known data.
        for (int i = 0; i < 4; i++) poke(32'h010 + i, 32'hA0 + i);
        run_copy(32'h010, 32'h100, 4, 0, 0);
        for (int i = 0; i < 4; i++) check("basic_dst", 64'(mem[32'h100 + i]), 64'(32'hA0 + i));

        run_copy(32'h050, 32'h060, 0, 0, 0);
        run_copy(32'hFFE, 32'h7FF, 3, 0, 0);
        run_copy(32'h300, 32'h400, 8, 6, 4);

        poke(32'h020, 32'h55);
        run_copy(32'h020, 32'h021, 3, 0, 0);
        for (int i = 1; i < 4; i++) check("overlap_dst", 64'(mem[32'h020 + i]), 64'h55);

        // Reset in the LATCH cycle of word 1 abandons the copy after word 0 landed.
        start   = 1'b1;
        srcAddr = 12'h200;
        dstAddr = 12'h300;
        length  = 13'd4;
        saw_write = 1'b0;
        saw_done  = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_words", 64'(wordsCopied), 64'd0);
        check("midrst_addr", 64'(memAddress), 64'd0);
        check("midrst_write", 64'(memWrite), 64'd0);
        check("midrst_data", 64'(memDataOut), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (memWrite) saw_write = 1'b1;
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_write", 64'(saw_write), 64'd0);
        check("midrst_no_done", 64'(saw_done), 64'd0);
        check("midrst_word0", 64'(mem[12'h300]), 64'(ref_mem[12'h200]));
        check("midrst_word1", 64'(mem[12'h301]), 64'(ref_mem[12'h301]));
        ref_mem[12'h300] = ref_mem[12'h200];
        $display("copy src=200 dst=300 len=4 reset in cycle 5");
        run_copy(32'h200, 32'h300, 4, 0, 0);

        for (int t = 0; t < 8; t++) begin
            len = $urandom_range(20, 1);
            ab  = ($urandom_range(1, 0) == 1) ? $urandom_range(3 * len, 1) : 0;
            ex  = (ab == 0) ? $urandom_range(3 * len, 2) : 0;
            run_copy($urandom & MASK, $urandom & MASK, len, ab, ex);
        end

        run_copy(32'h123, 32'h800, 1 << AW, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copier.md
MEM_COPIER -- requirements
Module: mem_copier

Interface
REQ-001 Parameter s, default 12, the memory address width in bits; the memory holds 2**s 32-bit words.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a copy; sampled only in IDLE.
REQ-005 abort  input  1  request to end the copy early; sampled in READ, LATCH and WRITE.
REQ-006 srcAddr  input  s  first source word address; captured when start is accepted.
REQ-007 dstAddr  input  s  first destination word address; captured when start is accepted.
REQ-008 length  input  s+1  number of words to copy (0..2**s); captured when start is accepted.
REQ-009 busy  output  1  high in states READ, LATCH and WRITE.
REQ-010 done  output  1  one-cycle pulse, high only in state DONE.
REQ-011 wordsCopied  output  s+1  count of completed destination writes for the current or last copy.
REQ-012 memAddress  output  s  word address driven to the single-port memory.
REQ-013 memWrite  output  1  memory write enable.
REQ-014 memDataOut  output  32  write data driven to the memory data input.
REQ-015 memDataIn  input  32  memory read data, valid in the cycle after its address was presented.

Function
REQ-016 The FSM SHALL have states IDLE, READ, LATCH, WRITE and DONE; it SHALL leave reset in IDLE.
REQ-017 IDLE with start=1 SHALL capture srcAddr, dstAddr and length, clear the word index and wordsCopied, and go to READ if length!=0, otherwise to DONE.
REQ-018 In READ, memAddress SHALL be (src+index) mod 2**s and memWrite SHALL be 0; the next state SHALL be LATCH.
REQ-019 In LATCH, memAddress SHALL be 0 and memWrite 0; memDataIn SHALL be registered into an internal data buffer at the closing edge; the next state SHALL be WRITE.
REQ-020 In WRITE, memAddress SHALL be (dst+index) mod 2**s, memWrite SHALL be 1 and memDataOut SHALL equal the buffer.
REQ-021 At the closing edge of WRITE, the index and wordsCopied SHALL each increment by 1.
REQ-022 After WRITE, the next state SHALL be DONE if the incremented index equals length, otherwise READ.
REQ-023 Each word SHALL take exactly 3 cycles; for a start sampled at edge 0, word k SHALL be written in cycle 3k+3, and done SHALL be high in cycle 3N+1 (cycle 1 when N=0).
REQ-024 DONE SHALL last one cycle and then go to IDLE; start is not sampled in DONE.
REQ-025 start SHALL be ignored outside IDLE; srcAddr, dstAddr and length changes SHALL have no effect after capture.
REQ-026 abort=1 in READ, LATCH or WRITE SHALL force the next state to DONE.
REQ-027 The memory write of a WRITE cycle in which abort is high SHALL still occur and SHALL be counted in wordsCopied.
REQ-028 abort SHALL be ignored in IDLE and DONE.
REQ-029 Addresses SHALL wrap modulo 2**s; with length=2**s, every location SHALL be written exactly once.
REQ-030 The copy SHALL be strictly ascending with no overlap correction; a destination overlapping the source at a higher address replicates source data, and this is the defined behaviour.
REQ-031 In IDLE and DONE, memAddress SHALL be 0, memWrite 0, and memDataOut SHALL hold the buffer value.
REQ-032 wordsCopied SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-033 rst=1 SHALL immediately, without waiting for a clock edge, force state IDLE, index, wordsCopied and buffer to 0, busy=0, done=0, memWrite=0, memAddress=0 and memDataOut=0.
REQ-034 rst asserted mid-copy SHALL abandon the copy; no further memory writes SHALL occur, and done SHALL NOT pulse for the abandoned copy.
REQ-035 After rst deasserts, a start SHALL be required to begin a new copy.

Verification (bench memory model: 1-cycle registered read, s=12)
REQ-036 Preload mem[0x010..0x013]=0xA0..0xA3; start with src=0x010, dst=0x100, length=4 -> mem[0x100..0x103]=0xA0..0xA3, done in cycle 13, wordsCopied=4, busy high in cycles 1..12.
REQ-037 length=0 -> done in cycle 1, busy never high, memWrite never high, wordsCopied=0.
REQ-038 src=0xFFE, dst=0x7FF, length=3 -> reads from 0xFFE, 0xFFF, 0x000; writes to 0x7FF, 0x800, 0x801.
REQ-039 length=8, abort in cycle 6 (WRITE of word 1) -> exactly two writes occur, done in cycle 7, wordsCopied=2; a second start during the copy has no effect.
REQ-040 rst pulsed in cycle 5 of a 4-word copy -> all outputs 0 immediately, the destination holds only word 0, no done pulse; a new start then completes normally.
REQ-041 Overlapping copy src=0x020, dst=0x021, length=3 with mem[0x020]=0x55 -> mem[0x021..0x023]=0x55.
